cnt_ext_tracker: RTL



---
 rtl/cnt_ext_pkg.sv | 16 +
 rtl/cnt_ext_if.sv | 13 +
 rtl/cnt_ext_fifo.sv | 57 +++++
 rtl/cnt_ext_tracker.sv | 120 ++++++++++++
 4 files changed

// File: rtl/cnt_ext_pkg.sv
// Shared types and constants for the extended-count tracker.
// Holds the FSM state encoding, the mod-4 step codes and the drop-counter ceiling.
package cnt_ext_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [1:0] STEP_NONE = 2'd0;
    localparam logic [1:0] STEP_INC  = 2'd1;

    localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/cnt_ext_if.sv
// Valid/ready report channel carrying extended-count snapshots.
// The tracker drives it through the master modport; the consumer uses slave.
interface cnt_ext_if #(
    parameter int W = 16
);
    logic         rpt_valid;
    logic         rpt_ready;
    logic [W-1:0] rpt_data;

    modport master (output rpt_valid, output rpt_data, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_data, output rpt_ready);

endinterface

// File: rtl/cnt_ext_fifo.sv
// Synchronous W x DEPTH report FIFO with synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cnt_ext_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty reads as zero so the head never shows a stale entry.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cnt_ext_tracker.sv
// Decodes mod-4 steps of an upstream 2-bit counter into a wide extended count,
// flags illegal steps and queues periodic snapshots on a valid/ready channel.
module cnt_ext_tracker
    import cnt_ext_pkg::*;
#(
    parameter int W            = 16,
    parameter int REPORT_SHIFT = 4,
    parameter int DEPTH        = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [1:0]   cnt_in,
    output logic [W-1:0] ext_cnt,
    output logic         wrap,
    output logic         err,
    output logic [7:0]   drop_cnt,
    cnt_ext_if.master    rpt
);
    state_t       state_q;
    state_t       state_d;
    logic [1:0]   in_q;
    logic [1:0]   prev_q;
    logic [1:0]   delta;
    logic         base_load;
    logic         track;
    logic         inc;
    logic         bad;
    logic [W-1:0] ext_next;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic         drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ARM;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     state_d = TRACK;
                TRACK:   state_d = TRACK;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        base_load = 1'b0;
        track     = 1'b0;
        if (!clr) begin
            base_load = (state_q == ARM) || (state_q == TRACK);
            track     = (state_q == TRACK);
        end
    end

    // Baseline follows every step in ARM/TRACK, even when disabled or illegal.
    assign delta    = in_q - prev_q;
    assign inc      = track && en && (delta == STEP_INC);
    assign bad      = track && (delta != STEP_NONE) && (delta != STEP_INC);
    assign ext_next = ext_cnt + W'(1);
    assign push     = inc && (ext_next[REPORT_SHIFT-1:0] == '0);
    assign pop      = !empty && rpt.rpt_ready;
    assign drop     = push && full && !pop;

    assign rpt.rpt_valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_q <= '0;
        else        in_q <= cnt_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            ext_cnt  <= '0;
            wrap     <= 1'b0;
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            prev_q   <= '0;
            ext_cnt  <= '0;
            wrap     <= 1'b0;
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (base_load) prev_q <= in_q;
            if (inc) begin
                ext_cnt <= ext_next;
                if (&ext_cnt) wrap <= 1'b1;
            end
            if (bad) err <= 1'b1;
            if (drop && (drop_cnt != DROP_MAX)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    cnt_ext_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (ext_next),
        .dout  (rpt.rpt_data),
        .full  (full),
        .empty (empty)
    );

endmodule
